// File: rtl/phv_dispatch_pkg.sv
// -----------------------------------------------------------------------------
// phv_dispatch_pkg
// Shared types and helpers for the PHV output dispatcher:
//   - qmask_t       : queue mask wide enough for the largest channel count (8)
//   - empty_mode_e  : what to do with a PHV whose queue mask is all zero
//   - ptr_w/cnt_w   : FIFO pointer / occupancy widths derived from a depth
//   - popcount      : number of set bits in a queue mask
//   - eff_mask      : mask actually used for pushing, after empty-mask policy
// -----------------------------------------------------------------------------
package phv_dispatch_pkg;

  localparam int MAX_QUEUES = 8;

  typedef logic [MAX_QUEUES-1:0] qmask_t;

  typedef enum logic {
    EMPTY_DROP    = 1'b0,
    EMPTY_DEFAULT = 1'b1
  } empty_mode_e;

  // Pointer width for a power-of-two depth; pointers wrap naturally.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Occupancy needs one extra bit so that "full" (== depth) is representable.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic logic [3:0] popcount(input qmask_t mask);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < MAX_QUEUES; i++) begin
      n = n + 4'(mask[i]);
    end
    return n;
  endfunction

  function automatic qmask_t eff_mask(input qmask_t mask, input empty_mode_e mode,
                                      input int default_q);
    if (mask != '0) begin
      return mask;
    end
    if (mode == EMPTY_DEFAULT) begin
      return qmask_t'(1) << default_q;
    end
    return '0;
  endfunction

endpackage

// File: rtl/phv_chan_fifo.sv
// -----------------------------------------------------------------------------
// phv_chan_fifo
// Per-channel PHV FIFO. Storage is a small register array; the head entry is
// read straight out of that array, so output data comes from registers only.
// dout is forced to zero while the FIFO is empty so an idle channel shows 0.
//
// Ports:
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset (clears pointers and occupancy)
//   push   in   write din this cycle (never asserted while full)
//   din    in   [WIDTH] data to write
//   pop    in   remove head entry (ignored while empty)
//   dout   out  [WIDTH] head entry, zero when empty
//   empty  out  no entries held
//   full   out  DEPTH entries held
// -----------------------------------------------------------------------------
module phv_chan_fifo
  import phv_dispatch_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_pop;

  assign do_pop = pop && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    // Push and pop together leave occupancy unchanged.
    case ({push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Data storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign dout  = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/phv_out_dispatch.sv
// -----------------------------------------------------------------------------
// phv_out_dispatch
// Output stage of the last pipeline stage. Fans each accepted PHV out to every
// channel selected by the multi-hot queue mask at phv_in[QUEUE_OFF +: N],
// buffering per channel so a stalled consumer only blocks input once full.
//
// Ports:
//   axis_clk       in   clock
//   aresetn        in   asynchronous active-low reset
//   phv_in         in   [PHV_LEN] PHV from the action engine
//   phv_in_valid   in   phv_in is valid
//   phv_in_ready   out  a PHV can be accepted this cycle
//   phv_out        out  [C_NUM_QUEUES*PHV_LEN] channel q at [q*PHV_LEN +: PHV_LEN]
//   phv_out_valid  out  [C_NUM_QUEUES] per-channel valid
//   phv_out_ready  in   [C_NUM_QUEUES] per-channel ready
//   drop_cnt       out  [CNT_WIDTH] PHVs dropped for an empty mask (saturating)
//   mcast_cnt      out  [CNT_WIDTH] accepted PHVs with >= 2 mask bits (saturating)
// -----------------------------------------------------------------------------
module phv_out_dispatch
  import phv_dispatch_pkg::*;
#(
  parameter int PHV_LEN         = 48*8+32*8+16*8+256,
  parameter int C_NUM_QUEUES    = 4,
  parameter int QUEUE_OFF       = 141,
  parameter int FIFO_DEPTH      = 4,
  parameter int EMPTY_MASK_MODE = 0,
  parameter int DEFAULT_QUEUE   = 0,
  parameter int CNT_WIDTH       = 32
) (
  input  logic                              axis_clk,
  input  logic                              aresetn,
  input  logic [PHV_LEN-1:0]                phv_in,
  input  logic                              phv_in_valid,
  output logic                              phv_in_ready,
  output logic [C_NUM_QUEUES*PHV_LEN-1:0]   phv_out,
  output logic [C_NUM_QUEUES-1:0]           phv_out_valid,
  input  logic [C_NUM_QUEUES-1:0]           phv_out_ready,
  output logic [CNT_WIDTH-1:0]              drop_cnt,
  output logic [CNT_WIDTH-1:0]              mcast_cnt
);

  localparam empty_mode_e MODE = (EMPTY_MASK_MODE != 0) ? EMPTY_DEFAULT : EMPTY_DROP;

  logic [C_NUM_QUEUES-1:0] raw_mask;
  logic [C_NUM_QUEUES-1:0] push_mask;
  logic [C_NUM_QUEUES-1:0] fifo_empty;
  logic [C_NUM_QUEUES-1:0] fifo_full;
  logic [C_NUM_QUEUES-1:0] fifo_pop;
  logic                    accept;
  logic                    rdy_en_q;
  logic [CNT_WIDTH-1:0]    drop_cnt_q, drop_cnt_d;
  logic [CNT_WIDTH-1:0]    mcast_cnt_q, mcast_cnt_d;

  // Only the low C_NUM_QUEUES bits of the mask field matter.
  assign raw_mask = phv_in[QUEUE_OFF +: C_NUM_QUEUES];

  // Ready is a function of FIFO state alone: with no channel full, every
  // channel a multicast might target is guaranteed a free slot, so a PHV is
  // either pushed everywhere it belongs or not accepted at all.
  // rdy_en_q keeps ready low while in reset and lets it rise at the first edge.
  assign phv_in_ready = rdy_en_q && !(|fifo_full);
  assign accept       = phv_in_valid && phv_in_ready;

  assign push_mask = accept
                   ? C_NUM_QUEUES'(eff_mask(qmask_t'(raw_mask), MODE, DEFAULT_QUEUE))
                   : '0;

  assign phv_out_valid = ~fifo_empty;
  assign fifo_pop      = phv_out_valid & phv_out_ready;

  for (genvar q = 0; q < C_NUM_QUEUES; q++) begin : g_chan
    phv_chan_fifo #(
      .WIDTH (PHV_LEN),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (axis_clk),
      .rst_n (aresetn),
      .push  (push_mask[q]),
      .din   (phv_in),
      .pop   (fifo_pop[q]),
      .dout  (phv_out[q*PHV_LEN +: PHV_LEN]),
      .empty (fifo_empty[q]),
      .full  (fifo_full[q])
    );
  end

  // Statistics counters stop at all-ones instead of wrapping.
  always_comb begin
    drop_cnt_d  = drop_cnt_q;
    mcast_cnt_d = mcast_cnt_q;
    if (accept && (raw_mask == '0) && (MODE == EMPTY_DROP) && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
    end
    if (accept && (popcount(qmask_t'(raw_mask)) >= 4'd2) && (mcast_cnt_q != '1)) begin
      mcast_cnt_d = mcast_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      rdy_en_q    <= 1'b0;
      drop_cnt_q  <= '0;
      mcast_cnt_q <= '0;
    end else begin
      rdy_en_q    <= 1'b1;
      drop_cnt_q  <= drop_cnt_d;
      mcast_cnt_q <= mcast_cnt_d;
    end
  end

  assign drop_cnt  = drop_cnt_q;
  assign mcast_cnt = mcast_cnt_q;

endmodule

// File: tb/tb_phv_out_dispatch.sv
module tb_phv_out_dispatch;

  localparam int PHV_LEN = 48*8+32*8+16*8+256;
  localparam int NQ      = 4;
  localparam int QOFF    = 141;
  localparam int DEPTH   = 4;
  localparam int CW      = 4;
  localparam int DEFQ    = 2;

  typedef logic [PHV_LEN-1:0] phv_t;

  typedef struct {
    logic          vld;
    logic [NQ-1:0] mask;
    logic [3:0]    hi;      // bits just above the mask field
    logic [31:0]   seed;
    logic [NQ-1:0] ev0;     // expected valid, drop-mode instance
    logic [NQ-1:0] ev1;     // expected valid, default-queue instance
    logic [CW-1:0] edrop0;
    logic [CW-1:0] edrop1;
    logic [CW-1:0] emc;
  } vec_t;

  logic                  axis_clk = 1'b0;
  logic                  aresetn  = 1'b1;
  phv_t                  phv_in   = '0;
  logic                  phv_in_valid  = 1'b0;
  logic [NQ-1:0]         phv_out_ready = '0;
  logic [NQ*PHV_LEN-1:0] out_d  [2];
  logic [NQ-1:0]         outv_d [2];
  logic                  rdy_d  [2];
  logic [CW-1:0]         drop_d [2];
  logic [CW-1:0]         mcast_d[2];

  always #5 axis_clk = ~axis_clk;

  phv_out_dispatch #(
    .PHV_LEN(PHV_LEN), .C_NUM_QUEUES(NQ), .QUEUE_OFF(QOFF), .FIFO_DEPTH(DEPTH),
    .EMPTY_MASK_MODE(0), .DEFAULT_QUEUE(0), .CNT_WIDTH(CW)
  ) dut_drop (
    .axis_clk(axis_clk), .aresetn(aresetn), .phv_in(phv_in), .phv_in_valid(phv_in_valid),
    .phv_in_ready(rdy_d[0]), .phv_out(out_d[0]), .phv_out_valid(outv_d[0]),
    .phv_out_ready(phv_out_ready), .drop_cnt(drop_d[0]), .mcast_cnt(mcast_d[0])
  );

  phv_out_dispatch #(
    .PHV_LEN(PHV_LEN), .C_NUM_QUEUES(NQ), .QUEUE_OFF(QOFF), .FIFO_DEPTH(DEPTH),
    .EMPTY_MASK_MODE(1), .DEFAULT_QUEUE(DEFQ), .CNT_WIDTH(CW)
  ) dut_dflt (
    .axis_clk(axis_clk), .aresetn(aresetn), .phv_in(phv_in), .phv_in_valid(phv_in_valid),
    .phv_in_ready(rdy_d[1]), .phv_out(out_d[1]), .phv_out_valid(outv_d[1]),
    .phv_out_ready(phv_out_ready), .drop_cnt(drop_d[1]), .mcast_cnt(mcast_d[1])
  );

  // Reference model: one queue per channel per instance plus counters.
  phv_t          mq[2][NQ][$];
  logic [CW-1:0] m_drop [2];
  logic [CW-1:0] m_mcast[2];
  bit            m_started;

  int n_cmp  = 0;
  int n_fail = 0;

  function automatic bit m_ready(input int d);
    if (!m_started) return 1'b0;
    for (int q = 0; q < NQ; q++) begin
      if (mq[d][q].size() >= DEPTH) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic bit model_empty();
    for (int d = 0; d < 2; d++)
      for (int q = 0; q < NQ; q++)
        if (mq[d][q].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      for (int q = 0; q < NQ; q++) mq[d][q].delete();
      m_drop[d]  = '0;
      m_mcast[d] = '0;
    end
    m_started = 1'b0;
  endtask

  // Applied at each rising edge with the inputs that were present before it.
  task automatic model_edge();
    bit            rdy[2];
    logic [NQ-1:0] m;
    int            ones;
    if (!aresetn) return;
    for (int d = 0; d < 2; d++) rdy[d] = m_ready(d);
    for (int d = 0; d < 2; d++) begin
      for (int q = 0; q < NQ; q++)
        if (mq[d][q].size() > 0 && phv_out_ready[q]) void'(mq[d][q].pop_front());
      if (phv_in_valid && rdy[d]) begin
        m    = phv_in[QOFF +: NQ];
        ones = $countones(m);
        if (ones == 0) begin
          if (d == 0) begin
            if (m_drop[d] != '1) m_drop[d] = m_drop[d] + CW'(1);
          end else begin
            mq[d][DEFQ].push_back(phv_in);
          end
        end else begin
          for (int q = 0; q < NQ; q++) if (m[q]) mq[d][q].push_back(phv_in);
          if (ones >= 2 && m_mcast[d] != '1) m_mcast[d] = m_mcast[d] + CW'(1);
        end
      end
    end
    m_started = 1'b1;
  endtask

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmpw(input string name, input phv_t act, input phv_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got ..%h expected ..%h (low 64 bits) at %0t",
               name, act[63:0], exp[63:0], $time);
    end
  endtask

  task automatic check_all(input string tag);
    phv_t e;
    for (int d = 0; d < 2; d++) begin
      cmp($sformatf("%s.d%0d.ready", tag, d), 64'(rdy_d[d]), 64'(m_ready(d)));
      for (int q = 0; q < NQ; q++) begin
        cmp($sformatf("%s.d%0d.valid%0d", tag, d, q), 64'(outv_d[d][q]),
            64'(mq[d][q].size() > 0));
        e = (mq[d][q].size() > 0) ? mq[d][q][0] : '0;
        cmpw($sformatf("%s.d%0d.data%0d", tag, d, q), out_d[d][q*PHV_LEN +: PHV_LEN], e);
      end
      cmp($sformatf("%s.d%0d.drop", tag, d),  64'(drop_d[d]),  64'(m_drop[d]));
      cmp($sformatf("%s.d%0d.mcast", tag, d), 64'(mcast_d[d]), 64'(m_mcast[d]));
    end
  endtask

  task automatic step(input string tag);
    @(posedge axis_clk);
    model_edge();
    @(negedge axis_clk);
    check_all(tag);
  endtask

  // Reset asserted asynchronously between edges; state checked while held.
  task automatic do_reset();
    @(negedge axis_clk);
    #2;
    aresetn = 1'b0;
    model_clear();
    #1;
    check_all("in_reset");
    phv_in_valid  = 1'b0;
    phv_out_ready = '1;
    @(negedge axis_clk);
    @(negedge axis_clk);
    aresetn = 1'b1;
    step("after_reset");
  endtask

  function automatic phv_t mk_phv(input logic [31:0] seed, input logic [NQ-1:0] mask,
                                  input logic [3:0] hi);
    phv_t p;
    for (int w = 0; w < PHV_LEN/32; w++) p[w*32 +: 32] = seed ^ 32'(w);
    p[QOFF +: NQ]     = mask;
    p[QOFF + NQ +: 4] = hi;
    return p;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl[9];
    phv_t cur, held, r;
    int   idx, n_pop1, n_low, n_valid;
    bit   acc;
    logic [NQ-1:0] rm;

    tbl[0] = '{1'b1, 4'b0100, 4'h0, 32'hA5A5A5A5, 4'b0100, 4'b0100, 4'd0, 4'd0, 4'd0};
    tbl[1] = '{1'b1, 4'b0000, 4'h0, 32'h11111111, 4'b0000, 4'b0100, 4'd1, 4'd0, 4'd0};
    tbl[2] = '{1'b1, 4'b0000, 4'h0, 32'h22222222, 4'b0000, 4'b0100, 4'd2, 4'd0, 4'd0};
    tbl[3] = '{1'b1, 4'b0000, 4'hF, 32'h33333333, 4'b0000, 4'b0100, 4'd3, 4'd0, 4'd0};
    tbl[4] = '{1'b1, 4'b1011, 4'h0, 32'h44444444, 4'b1011, 4'b1011, 4'd3, 4'd0, 4'd1};
    tbl[5] = '{1'b1, 4'b1111, 4'h0, 32'h55555555, 4'b1111, 4'b1111, 4'd3, 4'd0, 4'd2};
    tbl[6] = '{1'b1, 4'b0001, 4'hF, 32'h66666666, 4'b0001, 4'b0001, 4'd3, 4'd0, 4'd2};
    tbl[7] = '{1'b0, 4'b1111, 4'h0, 32'h77777777, 4'b0000, 4'b0000, 4'd3, 4'd0, 4'd2};
    tbl[8] = '{1'b1, 4'b0110, 4'h0, 32'h88888888, 4'b0110, 4'b0110, 4'd3, 4'd0, 4'd3};

    // Table: unicast, empty masks in both modes, multicast, idle input
    do_reset();
    phv_out_ready = '1;
    for (int i = 0; i < 9; i++) begin
      cur = mk_phv(tbl[i].seed, tbl[i].mask, tbl[i].hi);
      phv_in       = cur;
      phv_in_valid = tbl[i].vld;
      @(posedge axis_clk);
      model_edge();
      @(negedge axis_clk);
      cmp($sformatf("vec%0d.ready0", i), 64'(rdy_d[0]), 64'(1));
      cmp($sformatf("vec%0d.ready1", i), 64'(rdy_d[1]), 64'(1));
      cmp($sformatf("vec%0d.valid0", i), 64'(outv_d[0]), 64'(tbl[i].ev0));
      cmp($sformatf("vec%0d.valid1", i), 64'(outv_d[1]), 64'(tbl[i].ev1));
      for (int q = 0; q < NQ; q++) begin
        if (tbl[i].ev0[q]) cmpw($sformatf("vec%0d.d0.data%0d", i, q),
                                out_d[0][q*PHV_LEN +: PHV_LEN], cur);
        if (tbl[i].ev1[q]) cmpw($sformatf("vec%0d.d1.data%0d", i, q),
                                out_d[1][q*PHV_LEN +: PHV_LEN], cur);
      end
      cmp($sformatf("vec%0d.drop0", i),  64'(drop_d[0]),  64'(tbl[i].edrop0));
      cmp($sformatf("vec%0d.drop1", i),  64'(drop_d[1]),  64'(tbl[i].edrop1));
      cmp($sformatf("vec%0d.mcast0", i), 64'(mcast_d[0]), 64'(tbl[i].emc));
      cmp($sformatf("vec%0d.mcast1", i), 64'(mcast_d[1]), 64'(tbl[i].emc));
    end
    phv_in_valid = 1'b0;
    step("table_tail");

    // Multicast 1011 with channel 1 stalled for 10 cycles
    do_reset();
    phv_out_ready = 4'b1101;
    idx = 0;
    n_pop1 = 0;
    for (int cyc = 0; cyc < 80 && !(idx == 10 && model_empty()); cyc++) begin
      if (cyc == 10) begin
        cmp("stall.accepted_before_release", 64'(idx), 64'(4));
        phv_out_ready = 4'b1111;
      end
      phv_in_valid = (idx < 10);
      phv_in       = mk_phv(32'hC0000000 + 32'(idx), 4'b1011, 4'h0);
      acc          = phv_in_valid && m_ready(0);
      if (outv_d[0][1] && phv_out_ready[1]) n_pop1++;
      step("stall");
      if (acc) idx++;
      if (cyc == 3) cmp("stall.ready_low_when_full", 64'(rdy_d[0]), 64'(0));
    end
    cmp("stall.all_sent", 64'(idx), 64'(10));
    cmp("stall.ch1_delivered", 64'(n_pop1), 64'(10));
    cmp("stall.mcast", 64'(mcast_d[0]), 64'(10));
    cmp("stall.drained", 64'(outv_d[0]), 64'(0));

    // Full-rate streaming on one channel
    do_reset();
    phv_out_ready = '1;
    n_low = 0;
    n_valid = 0;
    for (int i = 0; i < 100; i++) begin
      phv_in_valid = 1'b1;
      phv_in       = mk_phv(32'hD0000000 + 32'(i), 4'b0001, 4'h0);
      step("stream");
      if (rdy_d[0] !== 1'b1) n_low++;
      if (outv_d[0][0] === 1'b1) n_valid++;
    end
    phv_in_valid = 1'b0;
    step("stream_tail");
    cmp("stream.ready_drops", 64'(n_low), 64'(0));
    cmp("stream.valid_cycles", 64'(n_valid), 64'(100));

    // Backpressure hold on channel 0
    do_reset();
    phv_out_ready = '0;
    held = mk_phv(32'hBEEF0000, 4'b0001, 4'h0);
    phv_in = held;
    phv_in_valid = 1'b1;
    step("hold");
    phv_in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step("hold");
      cmpw($sformatf("hold.data%0d", k), out_d[0][PHV_LEN-1:0], held);
      cmp($sformatf("hold.valid%0d", k), 64'(outv_d[0][0]), 64'(1));
    end
    phv_out_ready[0] = 1'b1;
    step("hold");
    cmp("hold.popped", 64'(outv_d[0][0]), 64'(0));

    // Reset in the middle of operation with buffered entries
    do_reset();
    phv_out_ready = '0;
    for (int i = 0; i < 3; i++) begin
      phv_in = mk_phv(32'hE0000000 + 32'(i), 4'b0111, 4'h0);
      phv_in_valid = 1'b1;
      step("prerst");
    end
    phv_in = mk_phv(32'hE0000003, 4'b0000, 4'h0);
    step("prerst");
    phv_in_valid = 1'b0;
    cmp("prerst.mcast", 64'(mcast_d[0]), 64'(3));
    cmp("prerst.drop", 64'(drop_d[0]), 64'(1));
    do_reset();
    cmp("midrst.valid0", 64'(outv_d[0]), 64'(0));
    cur = mk_phv(32'hF00D0000, 4'b0010, 4'h0);
    phv_in = cur;
    phv_in_valid = 1'b1;
    step("postrst");
    phv_in_valid = 1'b0;
    cmp("postrst.valid", 64'(outv_d[0]), 64'(4'b0010));
    cmpw("postrst.data", out_d[0][PHV_LEN +: PHV_LEN], cur);

    // Counter saturation
    do_reset();
    phv_out_ready = '1;
    for (int i = 0; i < 40; i++) begin
      phv_in = mk_phv(32'(i), (i % 2 != 0) ? 4'b0011 : 4'b0000, 4'h0);
      phv_in_valid = 1'b1;
      step("sat");
    end
    phv_in_valid = 1'b0;
    cmp("sat.drop", 64'(drop_d[0]), 64'(4'hF));
    cmp("sat.mcast", 64'(mcast_d[0]), 64'(4'hF));
    cmp("sat.mcast_dflt", 64'(mcast_d[1]), 64'(4'hF));
    cmp("sat.drop_dflt", 64'(drop_d[1]), 64'(0));

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int w = 0; w < PHV_LEN/32; w++) r[w*32 +: 32] = $urandom();
      rm = NQ'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) rm = '0;
      r[QOFF +: NQ] = rm;
      phv_in       = r;
      phv_in_valid = ($urandom_range(0, 3) != 0);
      for (int q = 0; q < NQ; q++) begin
        if (c >= 1000 && c < 2000) phv_out_ready[q] = ($urandom_range(0, 3) == 0);
        else                       phv_out_ready[q] = ($urandom_range(0, 3) != 0);
      end
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
